ecc_nibble_io: RTL

//   Parametrised nibble-serial I/O front end for the ECC scalar-multiply core.

---
 rtl/ecc_nibble_io_if.sv | 29 ++
 rtl/ecc_nibble_io.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ecc_nibble_io_if.sv
// Signal bundle of the nibble-serial ECC front end: pin-side handshake and the
// parallel operand/result bus toward the scalar-multiply core.
interface ecc_nibble_io_if #(
   parameter int WIDTH = 32,
   parameter int NW    = 4
);
   logic             i_start;
   logic [NW-1:0]    i_a, i_prime, i_k, i_px, i_py;
   logic             o_busy, o_done, o_err, o_out_valid;
   logic [NW-1:0]    o_kpx, o_kpy;
   logic             core_start;
   logic [WIDTH-1:0] core_a, core_prime, core_k, core_px, core_py;
   logic             core_done;
   logic [WIDTH-1:0] core_rx, core_ry;

   modport master (
      output i_start, i_a, i_prime, i_k, i_px, i_py,
      input  o_busy, o_done, o_err, o_out_valid, o_kpx, o_kpy,
      input  core_start, core_a, core_prime, core_k, core_px, core_py,
      output core_done, core_rx, core_ry
   );

   modport slave (
      input  i_start, i_a, i_prime, i_k, i_px, i_py,
      output o_busy, o_done, o_err, o_out_valid, o_kpx, o_kpy,
      output core_start, core_a, core_prime, core_k, core_px, core_py,
      input  core_done, core_rx, core_ry
   );
endinterface

// File: rtl/ecc_nibble_io.sv
// Nibble-serial load of five operands, core launch with timeout, and nibble-serial
// return of the two result coordinates. An abort lands o_done/o_err on the TIMEOUT-th cycle after core_start.
module ecc_nibble_io #(
   parameter int WIDTH     = 32,
   parameter int NW        = 4,
   parameter int MSB_FIRST = 0,
   parameter int TIMEOUT   = 4096
) (
   input  logic           clk,
   input  logic           reset,
   ecc_nibble_io_if.slave bus
);
   localparam int BEATS = WIDTH / NW;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4,
      S_SHIFT = 3'd5
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [TW-1:0]    wcnt_r;
   logic             busy_r, done_r, err_r, valid_r, start_r;
   logic [NW-1:0]    kpx_r, kpy_r;
   logic [WIDTH-1:0] a_r, prime_r, k_r, px_r, py_r, rx_r, ry_r;
   logic [IW-1:0]    ld_base_s;

   // Beat n sits at nibble n (LSB order) or nibble BEATS-1-n (MSB order), same for load and stream.
   function automatic logic [IW-1:0] beat_base(input logic [CW-1:0] beat);
      logic [CW-1:0] pos;
      pos = (MSB_FIRST != 0) ? (LAST_BEAT - beat) : beat;
      return IW'(pos * NW);
   endfunction

   // Bit position of the nibble being loaded this cycle.
   always_comb begin
      if (state_r == S_IDLE) begin
         ld_base_s = beat_base('0);
      end else begin
         ld_base_s = beat_base(cnt_r);
      end
   end

   // Control FSM with registered outputs, operand and result storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         cnt_r   <= '0;
         wcnt_r  <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         valid_r <= 1'b0;
         start_r <= 1'b0;
         kpx_r   <= '0;
         kpy_r   <= '0;
         a_r     <= '0;
         prime_r <= '0;
         k_r     <= '0;
         px_r    <= '0;
         py_r    <= '0;
         rx_r    <= '0;
         ry_r    <= '0;
      end else begin
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         start_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.i_start) begin
                  a_r[ld_base_s +: NW]     <= bus.i_a;
                  prime_r[ld_base_s +: NW] <= bus.i_prime;
                  k_r[ld_base_s +: NW]     <= bus.i_k;
                  px_r[ld_base_s +: NW]    <= bus.i_px;
                  py_r[ld_base_s +: NW]    <= bus.i_py;
                  busy_r <= 1'b1;
                  if (BEATS > 1) begin
                     cnt_r   <= CW'(1);
                     state_r <= S_LOAD;
                  end else begin
                     cnt_r   <= '0;
                     start_r <= 1'b1;
                     state_r <= S_RUN;
                  end
               end
            end
            S_LOAD: begin
               a_r[ld_base_s +: NW]     <= bus.i_a;
               prime_r[ld_base_s +: NW] <= bus.i_prime;
               k_r[ld_base_s +: NW]     <= bus.i_k;
               px_r[ld_base_s +: NW]    <= bus.i_px;
               py_r[ld_base_s +: NW]    <= bus.i_py;
               if (cnt_r == LAST_BEAT) begin
                  cnt_r   <= '0;
                  start_r <= 1'b1;
                  state_r <= S_RUN;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            S_RUN: begin
               wcnt_r  <= TW'(1);
               state_r <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.core_done) begin
                  rx_r    <= bus.core_rx;
                  ry_r    <= bus.core_ry;
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end else if ((TIMEOUT != 0) && (wcnt_r >= WAIT_LAST)) begin
                  done_r  <= 1'b1;
                  err_r   <= 1'b1;
                  state_r <= S_DONE;
               end else begin
                  wcnt_r <= wcnt_r + TW'(1);
               end
            end
            S_DONE: begin
               // err_r is still high here only on the abort path, which skips the stream.
               if (err_r) begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  cnt_r   <= '0;
                  valid_r <= 1'b1;
                  kpx_r   <= rx_r[beat_base('0) +: NW];
                  kpy_r   <= ry_r[beat_base('0) +: NW];
                  state_r <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (cnt_r == LAST_BEAT) begin
                  cnt_r   <= '0;
                  valid_r <= 1'b0;
                  kpx_r   <= '0;
                  kpy_r   <= '0;
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
                  kpx_r <= rx_r[beat_base(cnt_r + CW'(1)) +: NW];
                  kpy_r <= ry_r[beat_base(cnt_r + CW'(1)) +: NW];
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_busy      = busy_r;
   assign bus.o_done      = done_r;
   assign bus.o_err       = err_r;
   assign bus.o_out_valid = valid_r;
   assign bus.o_kpx       = kpx_r;
   assign bus.o_kpy       = kpy_r;
   assign bus.core_start  = start_r;
   assign bus.core_a      = a_r;
   assign bus.core_prime  = prime_r;
   assign bus.core_k      = k_r;
   assign bus.core_px     = px_r;
   assign bus.core_py     = py_r;
endmodule
